imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Pipelined, parametrised RV immediate extender for the decode stage. It takes the upper 25 instruction bits plus a format select and returns the sign-extended immediate at XLEN width one cycle later. It covers I/S/B/U/J formats, flags illegal selects, and uses a valid/ready handshake with a 2-entry skid buffer so decode can stall without losing operands.

## Interface
- `XLEN`, default 32: output width; legal values 32 or 64.
- `TAG_W`, default 5: width of the sideband tag (e.g. rd index) carried alongside the immediate.
- `ERR_CNT_W`, default 16: width of the saturating illegal-select counter.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `imm_in`  in  25  instruction bits [31:7]; `imm_in[k]` = `instr[k+7]`.
- `imm_sel`  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm, macro-gated), others illegal.
- `tag_in`  in  TAG_W  sideband, passed through unmodified.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the output beat.
- `imm_out`  out  XLEN  extended immediate.
- `tag_out`  out  TAG_W  tag of the beat.
- `err_out`  out  1  beat had an illegal select.
- `err_cnt`  out  ERR_CNT_W  count of accepted illegal beats; saturates at all-ones.

## Operation
- Formats, in instruction bits; `sx` means sign-extend from `instr[31]` to XLEN:
  - I: `sx(instr[31:20])`.
  - S: `sx({instr[31:25], instr[11:7]})`.
  - B: `sx({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`.
  - U: `sx({instr[31:12], 12'b0})`; this is a 32-bit value, sign-extended when XLEN=64.
  - J: `sx({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
- Illegal select:
  - Beat completes normally with `imm_out` = 0 and `err_out` = 1.
  - `err_cnt` increments on acceptance of the beat and saturates.
- Extension is combinational on the input side; the result is captured into the pipeline registers.
- Pipeline has two registers: a main register (drives the outputs) and a skid register.
  - Accept = `in_valid && in_ready`.
  - Main register is free when `!out_valid || out_ready`.
  - When main is free, it loads the skid register if the skid is valid (skid then clears); otherwise it loads the accepted beat.
  - When main is free but neither source is available, `out_valid` falls.
  - An accepted beat that cannot enter main is written to the skid register.
  - If main loads from the skid while a new beat is accepted in the same cycle, the new beat is written into the skid.
- `in_ready` is registered: `in_ready` = !(skid valid after this edge).
- Beats leave in acceptance order. No beat is dropped or duplicated.
- Output fields hold stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 beat per cycle while `out_ready` is held high.
- Under a stall, a second beat enters the skid and `in_ready` drops on the following cycle.
- `in_ready` rises again one cycle after the skid drains.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, skid empty.
  - `imm_out` = 0, `tag_out` = 0, `err_out` = 0, `err_cnt` = 0.
- Reset mid-operation discards both registered beats. No handshake completes in the reset cycle.
- `in_valid` is ignored while `in_ready` = 0.

## Configuration
- `IMM_EXT_ZIMM_EN` defined: select 101 is legal and returns `{(XLEN-5)'b0, instr[19:15]}` (CSR zimm, zero-extended).
- `IMM_EXT_ZIMM_EN` not defined: select 101 is illegal (`imm_out` = 0, `err_out` = 1, counted).

## Structure
- Shared package `imm_ext_pkg` holds:
  - `imm_sel_e` enum (I/S/B/U/J/Z codes).
  - A packed beat struct (imm, tag, err), parametrised via XLEN-sized localparams.
- Combinational extender sub-module `imm_ext_core`: `imm_in` + `imm_sel` + XLEN in, imm + err out.
- The top level instantiates `imm_ext_core` and implements the skid pipeline and counter.

## Test plan
- I, XLEN=32, `instr` = 0xFFF00093, out_ready held 1 -> `imm_out` = 0xFFFFFFFF, one cycle later; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- Format sweep:
  - S, sw imm=-4 -> 0xFFFFFFFC.
  - B, imm=-8 -> 0xFFFFFFF8.
  - U, `instr` = 0x123450B7 -> 0x12345000.
  - J, `instr` = 0x001000EF -> 0x00000800.
- Select 110 with tag 7 -> `imm_out` = 0, `err_out` = 1, `tag_out` = 7, `err_cnt` 0->1. With ERR_CNT_W=2, after 5 illegal beats `err_cnt` = 3.
- Select 101, `instr[19:15]` = 0x1F -> 0x0000001F with `IMM_EXT_ZIMM_EN`; without it, 0 with `err_out` = 1.
- Backpressure:
  - Stream beats A, B, C with tags 1, 2, 3, `out_ready` = 0 -> A held on output, B in skid, `in_ready` = 0 from the cycle after B, C stalled.
  - Release `out_ready` -> tags exit 1, 2, 3 in consecutive cycles, nothing lost.
- Assert `rst` for 1 cycle with both registers full -> next cycle `out_valid` = 0, `in_ready` = 1, `err_cnt` = 0; a fresh beat then completes with 1-cycle latency.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the RV immediate extender pipeline.
// Beat storage uses the widest XLEN/TAG_W; the top slices down to its parameters.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        SEL_I = 3'b000,
        SEL_S = 3'b001,
        SEL_B = 3'b010,
        SEL_U = 3'b011,
        SEL_J = 3'b100,
        SEL_Z = 3'b101
    } imm_sel_e;

    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic [TAG_W_MAX-1:0] tag;
        logic                 err;
    } beat_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational I/S/B/U/J immediate extender with illegal-select flag.
// Select 101 (CSR zimm) is legal only when IMM_EXT_ZIMM_EN is defined.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     imm_in,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // imm_in[k] is instr[k+7]; every format is built as a 32-bit value
    // whose bit 31 is the sign, so one sign extension covers all of them.
    logic        s;
    logic [31:0] v;

    assign s = imm_in[24];

    always_comb begin
        v   = '0;
        err = 1'b0;
        unique case (1'b1)
            (imm_sel == SEL_I): v = {{20{s}}, imm_in[24:13]};
            (imm_sel == SEL_S): v = {{20{s}}, imm_in[24:18], imm_in[4:0]};
            (imm_sel == SEL_B): v = {{19{s}}, s, imm_in[0], imm_in[23:18],
                                     imm_in[4:1], 1'b0};
            (imm_sel == SEL_U): v = {imm_in[24:5], 12'b0};
            (imm_sel == SEL_J): v = {{11{s}}, s, imm_in[12:5], imm_in[13],
                                     imm_in[23:14], 1'b0};
`ifdef IMM_EXT_ZIMM_EN
            (imm_sel == SEL_Z): v = {27'b0, imm_in[12:8]};
`endif
            default:            err = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: 1-cycle latency, valid/ready with 2-entry skid.
// Optional CSR zimm select via IMM_EXT_ZIMM_EN (see imm_ext_core).
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          imm_in,
    input  logic [2:0]           imm_sel,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 err_out,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    beat_t           in_beat;
    beat_t           main_q;
    beat_t           skid_q;
    logic            skid_v;
    logic            skid_v_nxt;
    logic            accept;
    logic            main_free;

    imm_ext_core #(
        .XLEN (XLEN)
    ) u_core (
        .imm_in  (imm_in),
        .imm_sel (imm_sel),
        .imm     (ext_imm),
        .err     (ext_err)
    );

    always_comb begin
        in_beat     = '0;
        in_beat.imm = IMM_W_MAX'(ext_imm);
        in_beat.tag = TAG_W_MAX'(tag_in);
        in_beat.err = ext_err;
    end

    assign accept    = in_valid && in_ready;
    assign main_free = !out_valid || out_ready;

    // Skid holds a beat whenever one is accepted that main cannot take.
    always_comb begin
        skid_v_nxt = skid_v;
        if (main_free) begin
            skid_v_nxt = skid_v && accept;
        end else if (accept) begin
            skid_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q    <= '0;
            skid_q    <= '0;
            skid_v    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            err_cnt   <= '0;
        end else begin
            if (main_free) begin
                if (skid_v) begin
                    main_q    <= skid_q;
                    out_valid <= 1'b1;
                end else if (accept) begin
                    main_q    <= in_beat;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (accept && (skid_v || !main_free)) begin
                skid_q <= in_beat;
            end
            skid_v   <= skid_v_nxt;
            in_ready <= !skid_v_nxt;
            if (accept && in_beat.err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign imm_out = main_q.imm[XLEN-1:0];
    assign tag_out = main_q.tag[TAG_W-1:0];
    assign err_out = main_q.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: XLEN=32 (2-bit counter) and XLEN=64
// instances share stimulus; random traffic is scored against a reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [24:0] imm_in;
    logic [2:0]  imm_sel;
    logic [4:0]  tag_in;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] imm_out;
    logic [4:0]  tag_out;
    logic        err_out;
    logic [1:0]  err_cnt;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [63:0] imm_out_w;
    logic [4:0]  tag_out_w;
    logic        err_out_w;
    logic [15:0] err_cnt_w;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .TAG_W(5), .ERR_CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_in    (imm_in),
        .imm_sel   (imm_sel),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .tag_out   (tag_out),
        .err_out   (err_out),
        .err_cnt   (err_cnt)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5), .ERR_CNT_W(16)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .imm_in    (imm_in),
        .imm_sel   (imm_sel),
        .tag_in    (tag_in),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .imm_out   (imm_out_w),
        .tag_out   (tag_out_w),
        .err_out   (err_out_w),
        .err_cnt   (err_cnt_w)
    );

    // Reference: decode the immediate with signed shifts on the whole word.
    function automatic void ref_ext(input logic [31:0] instr,
                                    input logic [2:0] sel,
                                    output logic [63:0] val,
                                    output logic err);
        longint s;
        s   = longint'($signed(instr));
        val = '0;
        err = 1'b0;
        case (sel)
            3'd0: val = s >>> 20;
            3'd1: val = ((s >>> 25) <<< 5) | longint'(instr[11:7]);
            3'd2: val = ((s >>> 31) <<< 12) | (longint'(instr[7]) << 11)
                      | (longint'(instr[30:25]) << 5)
                      | (longint'(instr[11:8]) << 1);
            3'd3: val = longint'($signed(instr & 32'hFFFF_F000));
            3'd4: val = ((s >>> 31) <<< 20) | (longint'(instr[19:12]) << 12)
                      | (longint'(instr[20]) << 11)
                      | (longint'(instr[30:21]) << 1);
`ifdef IMM_EXT_ZIMM_EN
            3'd5: val = longint'(instr[19:15]);
`endif
            default: err = 1'b1;
        endcase
        if (err) val = '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0/1",
                     out_valid, in_ready);
        end
        compared++;
        if (imm_out !== 32'h0 || tag_out !== 5'h0 || err_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_data: imm=%h tag=%h err=%b want 0",
                     imm_out, tag_out, err_out);
        end
        compared++;
        if (err_cnt !== 2'd0 || err_cnt_w !== 16'd0 || out_valid_w !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_cnt: cnt=%0d cnt64=%0d v64=%b want 0",
                     err_cnt, err_cnt_w, out_valid_w);
        end
    endtask

    task automatic test_formats();
        logic [31:0] ins [6] = '{32'hFFF0_0093, 32'hFE00_0E23, 32'hFE00_0CE3,
                                 32'h1234_50B7, 32'h0010_00EF, 32'h8000_00B7};
        logic [2:0]  sel [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        logic [31:0] e32 [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFF8,
                                 32'h1234_5000, 32'h0000_0800, 32'h8000_0000};
        logic [63:0] e64 [6] = '{64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFC,
                                 64'hFFFF_FFFF_FFFF_FFF8,
                                 64'h0000_0000_1234_5000,
                                 64'h0000_0000_0000_0800,
                                 64'hFFFF_FFFF_8000_0000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            imm_in    = ins[i][31:7];
            imm_sel   = sel[i];
            tag_in    = 5'(i + 1);
            @(negedge clk);
            in_valid = 1'b0;
            compared++;
            if (out_valid !== 1'b1 || imm_out !== e32[i] || err_out !== 1'b0
                || tag_out !== 5'(i + 1)) begin
                mismatched++;
                $display("FAIL fmt32[%0d]: v=%b imm=%h err=%b tag=%0d want 1/%h/0/%0d",
                         i, out_valid, imm_out, err_out, tag_out, e32[i], i + 1);
            end
            compared++;
            if (imm_out_w !== e64[i]) begin
                mismatched++;
                $display("FAIL fmt64[%0d]: imm=%h want %h", i, imm_out_w, e64[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] zi;
        compared++;
        if (err_cnt !== 2'd0) begin
            mismatched++;
            $display("FAIL cnt_pre: cnt=%0d want 0", err_cnt);
        end
        @(negedge clk);
        in_valid = 1'b1;
        imm_in   = 25'h1AB_CDEF;
        imm_sel  = 3'b110;
        tag_in   = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || imm_out !== 32'h0 || err_out !== 1'b1
            || tag_out !== 5'd7 || err_cnt !== 2'd1) begin
            mismatched++;
            $display("FAIL illegal: v=%b imm=%h err=%b tag=%0d cnt=%0d want 1/0/1/7/1",
                     out_valid, imm_out, err_out, tag_out, err_cnt);
        end
        zi = 32'h000F_8073;
        @(negedge clk);
        in_valid = 1'b1;
        imm_in   = zi[31:7];
        imm_sel  = 3'b101;
        tag_in   = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef IMM_EXT_ZIMM_EN
        compared++;
        if (imm_out !== 32'h1F || err_out !== 1'b0 || err_cnt !== 2'd1
            || imm_out_w !== 64'h1F) begin
            mismatched++;
            $display("FAIL zimm: imm=%h err=%b cnt=%0d imm64=%h want 1f/0/1",
                     imm_out, err_out, err_cnt, imm_out_w);
        end
`else
        compared++;
        if (imm_out !== 32'h0 || err_out !== 1'b1 || err_cnt !== 2'd2
            || imm_out_w !== 64'h0) begin
            mismatched++;
            $display("FAIL zimm_off: imm=%h err=%b cnt=%0d imm64=%h want 0/1/2",
                     imm_out, err_out, err_cnt, imm_out_w);
        end
`endif
    endtask

    task automatic test_err_sat();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        imm_sel  = 3'b111;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (err_cnt !== 2'd3 || err_cnt_w !== 16'd5) begin
            mismatched++;
            $display("FAIL err_sat: cnt=%0d cnt64=%0d want 3/5", err_cnt, err_cnt_w);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_tag [3] = '{5'd1, 5'd2, 5'd3};
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_sel   = 3'd0;
        imm_in    = 25'h00_1234;
        tag_in    = 5'd1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1 || tag_out !== 5'd1 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_a: v=%b tag=%0d rdy=%b want 1/1/1",
                     out_valid, tag_out, in_ready);
        end
        tag_in = 5'd2;
        @(negedge clk);
        tag_in = 5'd3;
        compared++;
        if (in_ready !== 1'b0 || tag_out !== 5'd1) begin
            mismatched++;
            $display("FAIL bp_b: rdy=%b tag=%0d want 0/1", in_ready, tag_out);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || tag_out !== 5'd1 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_hold: rdy=%b tag=%0d v=%b want 0/1/1",
                     in_ready, tag_out, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (out_valid !== 1'b1 || tag_out !== exp_tag[i]) begin
                mismatched++;
                $display("FAIL bp_drain[%0d]: v=%b tag=%0d want 1/%0d",
                         i, out_valid, tag_out, exp_tag[i]);
            end
            if (i == 1) begin
                compared++;
                if (in_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL bp_rdy: rdy=%b want 1", in_ready);
                end
            end
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
        end
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_empty: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fi;
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_sel   = 3'b111;
        tag_in    = 5'd10;
        @(negedge clk);
        tag_in = 5'd11;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_cnt !== 2'd2) begin
            mismatched++;
            $display("FAIL rm_full: rdy=%b v=%b cnt=%0d want 0/1/2",
                     in_ready, out_valid, err_cnt);
        end
        rst    = 1'b1;
        tag_in = 5'd12;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 2'd0
            || err_cnt_w !== 16'd0) begin
            mismatched++;
            $display("FAIL rm_post: v=%b rdy=%b cnt=%0d cnt64=%0d want 0/1/0/0",
                     out_valid, in_ready, err_cnt, err_cnt_w);
        end
        fi        = 32'h8000_0013;
        out_ready = 1'b1;
        imm_in    = fi[31:7];
        imm_sel   = 3'd0;
        tag_in    = 5'd13;
        @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || tag_out !== 5'd13 || imm_out !== 32'hFFFF_F800) begin
            mismatched++;
            $display("FAIL rm_fresh: v=%b tag=%0d imm=%h want 1/13/fffff800",
                     out_valid, tag_out, imm_out);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rm_single: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        int          cnt2  = 0;
        int          cnt16 = 0;
        bit          hold  = 1'b0;
        logic [31:0] h_imm;
        logic [4:0]  h_tag;
        logic        h_err;
        logic [31:0] instr;
        logic [63:0] rv;
        logic        re;
        exp_t        e;
        int          guard;
        do_reset();
        sb.delete();
        for (int c = 0; c < 800 + 40; c++) begin
            @(negedge clk);
            compared++;
            if (err_cnt !== 2'(cnt2) || err_cnt_w !== 16'(cnt16)) begin
                mismatched++;
                $display("FAIL rnd_cnt: cnt=%0d cnt64=%0d want %0d/%0d",
                         err_cnt, err_cnt_w, cnt2, cnt16);
            end
            if (hold) begin
                compared++;
                if (out_valid !== 1'b1 || imm_out !== h_imm || tag_out !== h_tag
                    || err_out !== h_err) begin
                    mismatched++;
                    $display("FAIL rnd_stable: imm=%h tag=%0d err=%b want %h/%0d/%b",
                             imm_out, tag_out, err_out, h_imm, h_tag, h_err);
                end
            end
            if (c < 800) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            instr   = $urandom;
            imm_in  = instr[31:7];
            imm_sel = 3'($urandom_range(0, 7));
            tag_in  = 5'($urandom);
            if (out_valid && out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL rnd_extra: tag=%0d with empty scoreboard", tag_out);
                end else begin
                    e = sb.pop_front();
                    if (imm_out !== e.imm[31:0] || imm_out_w !== e.imm
                        || tag_out !== e.tag || err_out !== e.err) begin
                        mismatched++;
                        $display("FAIL rnd_beat: imm=%h imm64=%h tag=%0d err=%b want %h/%0d/%b",
                                 imm_out, imm_out_w, tag_out, err_out,
                                 e.imm, e.tag, e.err);
                    end
                end
            end
            hold  = out_valid && !out_ready;
            h_imm = imm_out;
            h_tag = tag_out;
            h_err = err_out;
            if (in_valid && in_ready) begin
                ref_ext(instr, imm_sel, rv, re);
                e.imm = rv;
                e.tag = tag_in;
                e.err = re;
                sb.push_back(e);
                if (re) begin
                    if (cnt2 < 3) cnt2++;
                    cnt16++;
                end
            end
        end
        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rnd_drain: left=%0d v=%b want 0/0", sb.size(), out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        imm_in    = '0;
        imm_sel   = '0;
        tag_in    = '0;
        out_ready = 1'b1;
        test_reset();
        test_formats();
        test_illegal();
        test_err_sat();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
